// File: rtl/vga_timing_window.sv
// 1024x768 raster generator with two window read-request decodes and a
// pixel mux that puts FIFO data (or background) onto the RGB565 output.
module vga_timing_window #(
    parameter int          H_SYNC   = 136,
    parameter int          H_BACK   = 160,
    parameter int          H_DISP   = 1024,
    parameter int          H_FRONT  = 24,
    parameter int          H_TOTAL  = 1344,
    parameter int          V_SYNC   = 6,
    parameter int          V_BACK   = 29,
    parameter int          V_DISP   = 768,
    parameter int          V_FRONT  = 3,
    parameter int          V_TOTAL  = 806,
    parameter int          IMG_W    = 256,
    parameter int          IMG_H    = 208,
    parameter int          IMG_X    = 0,
    parameter int          IMG_Y    = 0,
    parameter int          IMG_W2   = 800,
    parameter int          IMG_H2   = 600,
    parameter int          IMG_X2   = 112,
    parameter int          IMG_Y2   = 84,
    parameter logic [15:0] BG_COLOR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        win_sel,
    input  logic [15:0] rd_data,
    output logic [11:0] hcnt,
    output logic [11:0] vcnt,
    output logic        first_rden,
    output logic        secon_rden,
    output logic        frame_start,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic [15:0] vga_rgb
);
    localparam int THB = H_SYNC + H_BACK;
    localparam int TVB = V_SYNC + V_BACK;

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    localparam logic [11:0] HS_END = 12'(H_SYNC);
    localparam logic [11:0] VS_END = 12'(V_SYNC);
    localparam logic [11:0] DE_H0  = 12'(THB);
    localparam logic [11:0] DE_H1  = 12'(THB + H_DISP);
    localparam logic [11:0] DE_V0  = 12'(TVB);
    localparam logic [11:0] DE_V1  = 12'(TVB + V_DISP);
    // Read windows open one pixel early to cover the FIFO's 1-cycle latency.
    localparam logic [11:0] W1_H0  = 12'(THB - 1 + IMG_X);
    localparam logic [11:0] W1_H1  = 12'(THB - 1 + IMG_X + IMG_W);
    localparam logic [11:0] W1_V0  = 12'(TVB + IMG_Y);
    localparam logic [11:0] W1_V1  = 12'(TVB + IMG_Y + IMG_H);
    localparam logic [11:0] W2_H0  = 12'(THB - 1 + IMG_X2);
    localparam logic [11:0] W2_H1  = 12'(THB - 1 + IMG_X2 + IMG_W2);
    localparam logic [11:0] W2_V0  = 12'(TVB + IMG_Y2);
    localparam logic [11:0] W2_V1  = 12'(TVB + IMG_Y2 + IMG_H2);

    logic [11:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic        r1_q, r1_d, r2_q, r2_d, fs_q, fs_d;
    logic        sel_q, win_q;

    // Decodes are taken on the next counter values so the registered
    // outputs line up with the counters presented in the same cycle.
    always_comb begin
        hcnt_d = hcnt_q + 12'd1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = 12'd0;
            vcnt_d = (vcnt_q == V_LAST) ? 12'd0 : vcnt_q + 12'd1;
        end
        hs_d = (hcnt_d >= HS_END);
        vs_d = (vcnt_d >= VS_END);
        de_d = (hcnt_d >= DE_H0) && (hcnt_d < DE_H1) &&
               (vcnt_d >= DE_V0) && (vcnt_d < DE_V1);
        r1_d = (hcnt_d >= W1_H0) && (hcnt_d < W1_H1) &&
               (vcnt_d >= W1_V0) && (vcnt_d < W1_V1);
        r2_d = (hcnt_d >= W2_H0) && (hcnt_d < W2_H1) &&
               (vcnt_d >= W2_V0) && (vcnt_d < W2_V1);
        fs_d = (hcnt_d == 12'd0) && (vcnt_d == 12'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcnt_q <= 12'd0;
            vcnt_q <= 12'd0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            de_q   <= 1'b0;
            r1_q   <= 1'b0;
            r2_q   <= 1'b0;
            fs_q   <= 1'b0;
            sel_q  <= 1'b0;
            win_q  <= 1'b0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            de_q   <= de_d;
            r1_q   <= r1_d;
            r2_q   <= r2_d;
            fs_q   <= fs_d;
            if (fs_d)
                sel_q <= win_sel;
            win_q  <= sel_q ? r2_q : r1_q;
        end
    end

    assign hcnt        = hcnt_q;
    assign vcnt        = vcnt_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_de      = de_q;
    assign first_rden  = r1_q;
    assign secon_rden  = r2_q;
    assign frame_start = fs_q;

    // Gating with de keeps FIFO data out of blanking even at a window edge.
    assign vga_rgb = (win_q && de_q) ? rd_data : (de_q ? BG_COLOR : 16'h0000);

endmodule

// File: doc/vga_timing_window.md
Name: vga_timing_window

Overview:
- Upstream timing source for the camera read synchroniser.
- Generates the 1024x768 display raster counters (hcnt/vcnt), syncs and display-enable.
- Generates two per-window SDRAM/FIFO read requests (first_rden, secon_rden), each asserted one pixel ahead of display for a 1-cycle-latency read FIFO.
- Muxes the returned FIFO pixel onto the VGA RGB output, with a background colour outside the selected window.

Parameters:
- H_SYNC, 136, hsync width (clocks)
- H_BACK, 160, horizontal back porch
- H_DISP, 1024, active pixels per line
- H_FRONT, 24, horizontal front porch
- H_TOTAL, 1344, clocks per line
- V_SYNC, 6, vsync width (lines)
- V_BACK, 29, vertical back porch
- V_DISP, 768, active lines
- V_FRONT, 3, vertical front porch
- V_TOTAL, 806, lines per frame
- IMG_W/IMG_H/IMG_X/IMG_Y, 256/208/0/0, window 1 size and offset within active area
- IMG_W2/IMG_H2/IMG_X2/IMG_Y2, 800/600/112/84, window 2 size and offset
- BG_COLOR, 16'h0000, RGB565 colour inside active area but outside the selected window

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- win_sel  in  1  0 = show window 1, 1 = show window 2; sampled only at frame start
- rd_data  in  16  RGB565 from read FIFO, valid 1 cycle after a rden
- hcnt  out  12  horizontal counter
- vcnt  out  12  vertical counter
- first_rden  out  1  window-1 read request
- secon_rden  out  1  window-2 read request
- frame_start  out  1  1-cycle pulse, frame wrap
- vga_hs  out  1  hsync, active low
- vga_vs  out  1  vsync, active low
- vga_de  out  1  active-area enable
- vga_rgb  out  16  pixel out

Behaviour:
- Timing constants: THB = H_SYNC+H_BACK (296); TVB = V_SYNC+V_BACK (35).
- Reset (rst_n low at a clk edge):
  - hcnt=0, vcnt=0; first_rden=secon_rden=0; frame_start=0; vga_de=0; vga_rgb=0; sel_q=0.
  - vga_hs=0 and vga_vs=0, consistent with position (0,0).
  - Reset applied mid-frame restarts at (0,0) on the next edge, no partial-line completion.
- Counters:
  - hcnt increments each cycle and wraps H_TOTAL-1 -> 0.
  - vcnt increments when hcnt==H_TOTAL-1 and wraps V_TOTAL-1 -> 0 on that same edge.
- Output alignment: vga_hs, vga_vs, vga_de, first_rden, secon_rden and frame_start are registered. Each is computed from the next counter values, so in any cycle it reflects the hcnt/vcnt presented in that same cycle.
- Sync and enable decodes (on current hcnt/vcnt):
  - vga_hs = 0 iff hcnt < H_SYNC.
  - vga_vs = 0 iff vcnt < V_SYNC.
  - vga_de = 1 iff THB <= hcnt < THB+H_DISP and TVB <= vcnt < TVB+V_DISP.
- Window read requests (decoded on current hcnt/vcnt, no wrap-around subtraction; comparisons are unsigned on 12 bits):
  - first_rden = 1 iff THB-1+IMG_X <= hcnt < THB-1+IMG_X+IMG_W and TVB+IMG_Y <= vcnt < TVB+IMG_Y+IMG_H.
  - secon_rden is the same decode using the *2 parameters.
  - Both windows may assert simultaneously; both are driven independently.
- frame_start = 1 only in the cycle where hcnt==0 and vcnt==0, excluding the first cycle after reset release.
- win_sel sampling: sel_q <= win_sel at the clock edge that produces frame_start. A win_sel change mid-frame takes effect at the next frame only.
- Pixel pipeline:
  - win_q = (sel_q ? secon_rden : first_rden), delayed one cycle; de_q = vga_de.
  - vga_rgb is combinational from registers: win_q ? rd_data : (vga_de ? BG_COLOR : 16'h0000).
  - rd_data must never reach vga_rgb outside the active area.
  - Latency: rden to matching pixel on vga_rgb = 1 cycle.
- A parameter set with THB-1+IMG_X+IMG_W > THB+H_DISP is illegal; no checking in RTL.

Test Plan:
- Counter wrap: release reset, run 1344*806 cycles -> hcnt 1343->0 with vcnt 805->0 on the same edge; frame_start high exactly once per 1,083,264 cycles.
- Sync/DE: vga_hs low for hcnt 0..135; vga_vs low for vcnt 0..5; vga_de high for hcnt 296..1319 and vcnt 35..802 (786,432 cycles per frame).
- Window 1: first_rden high for hcnt 295..550, vcnt 35..242 -> 53,248 assertions per frame; none at vcnt 243.
- Window 2 plus pixel mux: win_sel=1 before frame_start, rd_data = hcnt-derived ramp.
  - secon_rden high for hcnt 407..1206, vcnt 119..718.
  - vga_rgb equals rd_data one cycle later; BG_COLOR elsewhere in the active area; 0 in blanking.
- Mid-frame win_sel toggle at vcnt=400 -> vga_rgb source unchanged until the next frame_start, then switches.
- Reset mid-line at hcnt=700, vcnt=300 -> next edge hcnt=0, vcnt=0, all rden/de 0, vga_rgb=0; normal timing resumes.
